// File: rtl/cc_merge_resolver_pkg.sv
// Shared definitions for the connected-components merge resolver:
// default label width, label range, merge-pair width and drop counter width.
package cc_merge_resolver_pkg;

  localparam int LBL_WIDTH_DEF = 8;
  localparam int MAX_LABEL     = (1 << LBL_WIDTH_DEF) - 1;
  localparam int DROP_CNT_W    = 16;

  // A merge pair packs {max, min} side by side.
  function automatic int pair_w(input int lbl_w);
    return 2 * lbl_w;
  endfunction

endpackage

// File: rtl/cc_merge_resolver_lifo_bank.sv
// One stack bank of merge pairs: push/pop with occupancy count, full/empty
// flags and the top entry read straight from the storage registers.
module cc_merge_resolver_lifo_bank
  import cc_merge_resolver_pkg::*;
#(
  parameter int PAIR_W     = pair_w(LBL_WIDTH_DEF),
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [PAIR_W-1:0]     i_din,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [PAIR_W-1:0]     o_top
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [PAIR_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2-1:0] w_top_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty & ~i_push;
  // When full the low bits wrap to 0, so subtracting one still lands on the top slot.
  assign w_top_idx = r_count[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_top   = r_mem[w_top_idx];

  // Occupancy count; the only control state in a bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + (DEPTH_LOG2+1)'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - (DEPTH_LOG2+1)'(1);
    end
  end

  // Pair storage; contents are meaningless while the count excludes them.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_count[DEPTH_LOG2-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/cc_merge_resolver.sv
// Label-equivalence merge resolver: double-buffered LIFO banks swapped on
// row_start, duplicate/overflow filtering on push, and a two-stage drain into
// the merge table that yields to new-label writes.
module cc_merge_resolver
  import cc_merge_resolver_pkg::*;
#(
  parameter int LBL_WIDTH     = LBL_WIDTH_DEF,
  parameter int DEPTH_LOG2    = 8,
  parameter int RESOLVE_CHAIN = 1,
  parameter int DEDUP         = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  row_start,
  input  logic                  merge_valid,
  input  logic [LBL_WIDTH-1:0]  merge_min,
  input  logic [LBL_WIDTH-1:0]  merge_max,
  input  logic                  new_label_valid,
  input  logic [LBL_WIDTH-1:0]  new_label,
  output logic                  tbl_wen,
  output logic [LBL_WIDTH-1:0]  tbl_index,
  output logic [LBL_WIDTH-1:0]  tbl_target,
  output logic [LBL_WIDTH-1:0]  tbl_raddr,
  input  logic [LBL_WIDTH-1:0]  tbl_rdata,
  output logic                  push_bank,
  output logic                  drain_busy,
  output logic                  overflow,
  output logic                  late_drain,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int PAIR_W = pair_w(LBL_WIDTH);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic                  r_push_bank;
  logic                  r_overflow;
  logic                  r_late_drain;
  logic [DROP_CNT_W-1:0] r_drop_count;
  logic                  r_last_vld;
  logic [PAIR_W-1:0]     r_last_pair;
  logic                  r_vld_p2;
  logic [PAIR_W-1:0]     r_pair_p2;

  logic                  w_swap, w_nl, w_push_sel, w_drain_sel, w_old_drain;
  logic                  w_push_req, w_dup, w_accept, w_full_drop, w_pop;
  logic [PAIR_W-1:0]     w_pair;
  logic [LBL_WIDTH-1:0]  w_s2_min, w_s2_max, w_chain_tgt;
  logic [DEPTH_LOG2:0]   w_count [2];
  logic                  w_full  [2];
  logic                  w_empty [2];
  logic [PAIR_W-1:0]     w_top   [2];

  assign w_swap      = row_start & en;
  assign w_nl        = new_label_valid & en;
  // Banks are steered by the post-swap selection so a same-cycle push lands in the new row.
  assign w_push_sel  = r_push_bank ^ w_swap;
  assign w_drain_sel = ~w_push_sel;
  assign w_old_drain = ~r_push_bank;

  assign w_pair      = {merge_max, merge_min};
  assign w_push_req  = merge_valid & en & (merge_min != '0) & (merge_min != merge_max);
  assign w_dup       = (DEDUP != 0) & r_last_vld & ~w_swap & (w_pair == r_last_pair);
  assign w_accept    = w_push_req & ~w_dup & ~w_full[w_push_sel];
  assign w_full_drop = w_push_req & ~w_dup & w_full[w_push_sel];
  // S2 is always vacated on an enabled cycle without a new label, so only the stall blocks a pop.
  assign w_pop       = en & ~w_nl & ~w_empty[w_drain_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cc_merge_resolver_lifo_bank #(
      .PAIR_W     (PAIR_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_accept & (w_push_sel == 1'(b))),
      .i_pop   (w_pop & (w_drain_sel == 1'(b))),
      .i_din   (w_pair),
      .o_count (w_count[b]),
      .o_full  (w_full[b]),
      .o_empty (w_empty[b]),
      .o_top   (w_top[b])
    );
  end

  // Bank selection, sticky error flags, drop accounting and dedup history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_push_bank  <= 1'b0;
      r_overflow   <= 1'b0;
      r_late_drain <= 1'b0;
      r_drop_count <= '0;
      r_last_vld   <= 1'b0;
    end else if (en) begin
      if (w_swap) r_push_bank <= ~r_push_bank;
      if (w_swap && (w_count[w_old_drain] != '0)) r_late_drain <= 1'b1;
      if (w_full_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc(r_drop_count);
      end
      if (w_accept) r_last_vld <= 1'b1;
      else if (w_swap) r_last_vld <= 1'b0;
    end
  end

  // Last accepted pair, compared against incoming pushes for dedup.
  always_ff @(posedge clk) begin
    if (w_accept) r_last_pair <= w_pair;
  end

  // S1 -> S2 boundary: popped pair becomes the pending table write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p2 <= 1'b0;
    end else if (en && !w_nl) begin
      r_vld_p2 <= w_pop;
    end
  end

  // S2 pair payload; held while a new-label write takes the port.
  always_ff @(posedge clk) begin
    if (w_pop) r_pair_p2 <= w_top[w_drain_sel];
  end

  assign w_s2_min    = r_pair_p2[LBL_WIDTH-1:0];
  assign w_s2_max    = r_pair_p2[PAIR_W-1:LBL_WIDTH];
  assign w_chain_tgt = (RESOLVE_CHAIN != 0) ? tbl_rdata : w_s2_min;

  assign tbl_raddr  = r_vld_p2 ? w_s2_min : '0;
  assign tbl_wen    = w_nl | (en & r_vld_p2);
  assign tbl_index  = w_nl ? new_label : (r_vld_p2 ? w_s2_max : '0);
  assign tbl_target = w_nl ? new_label : (r_vld_p2 ? w_chain_tgt : '0);

  assign push_bank  = r_push_bank;
  assign drain_busy = (w_count[w_old_drain] != '0) | r_vld_p2;
  assign overflow   = r_overflow;
  assign late_drain = r_late_drain;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_cc_merge_resolver.sv
// Directed and randomized bench for cc_merge_resolver with a small merge-table
// RAM model and a row-level queue reference model.
module tb_cc_merge_resolver;

  logic        clk = 1'b0;
  logic        reset_n, en, row_start, merge_valid, new_label_valid;
  logic [7:0]  merge_min, merge_max, new_label;
  logic        tbl_wen, push_bank, drain_busy, overflow, late_drain;
  logic [7:0]  tbl_index, tbl_target, tbl_raddr, tbl_rdata;
  logic [15:0] drop_count;

  logic [7:0]  env_mt [256];
  bit          mt_wr  [256];
  logic [15:0] act_dr [$];
  logic [7:0]  act_nl [$];
  int          dr_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  cc_merge_resolver #(
    .LBL_WIDTH(8), .DEPTH_LOG2(2), .RESOLVE_CHAIN(1), .DEDUP(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .row_start(row_start),
    .merge_valid(merge_valid), .merge_min(merge_min), .merge_max(merge_max),
    .new_label_valid(new_label_valid), .new_label(new_label),
    .tbl_wen(tbl_wen), .tbl_index(tbl_index), .tbl_target(tbl_target),
    .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .push_bank(push_bank), .drain_busy(drain_busy), .overflow(overflow),
    .late_drain(late_drain), .drop_count(drop_count)
  );

  // Unwritten table entries read back as their own label.
  assign tbl_rdata = mt_wr[tbl_raddr] ? env_mt[tbl_raddr] : tbl_raddr;

  always @(posedge clk) begin
    if (tbl_wen) begin
      env_mt[tbl_index] <= tbl_target;
      mt_wr[tbl_index]  <= 1'b1;
      if (new_label_valid) act_nl.push_back(tbl_index);
      else begin
        act_dr.push_back({tbl_index, tbl_target});
        dr_cnt <= dr_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input int a, input int b);
    merge_valid = 1'b1;
    merge_min   = 8'(a);
    merge_max   = 8'(b);
    tick();
    merge_valid = 1'b0;
  endtask

  task automatic pulse_row();
    row_start = 1'b1;
    tick();
    row_start = 1'b0;
  endtask

  logic [15:0] cur [$];
  logic [15:0] exp_dr [$];
  logic [7:0]  exp_nl [$];
  logic [7:0]  ref_mt [256];

  initial begin
    int base, base_dr, base_nl, m_drop, nl_budget, a, b, n;
    bit m_ovf, m_last_vld, pv, nlv;
    logic [15:0] m_last, p, e;
    logic [7:0] lbl, tgt;

    reset_n = 1'b0; en = 1'b1; row_start = 1'b0; merge_valid = 1'b0;
    merge_min = '0; merge_max = '0; new_label_valid = 1'b0; new_label = '0;
    repeat (2) tick();
    mid();
    chk("rst_wen", 32'(tbl_wen), 0);
    chk("rst_index", 32'(tbl_index), 0);
    chk("rst_target", 32'(tbl_target), 0);
    chk("rst_raddr", 32'(tbl_raddr), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_late", 32'(late_drain), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_push_bank", 32'(push_bank), 0);
    chk("rst_busy", 32'(drain_busy), 0);
    tick();
    reset_n = 1'b1;

    // Two pairs, swap, LIFO drain at +1 and +2.
    push(3, 7); push(2, 5);
    row_start = 1'b1; mid(); chk("t1_swap_wen", 32'(tbl_wen), 0); tick(); row_start = 1'b0;
    chk("t1_push_bank", 32'(push_bank), 1);
    mid(); chk("t1_w1_wen", 32'(tbl_wen), 1); chk("t1_w1_idx", 32'(tbl_index), 5);
    chk("t1_w1_tgt", 32'(tbl_target), 2); chk("t1_busy", 32'(drain_busy), 1); tick();
    mid(); chk("t1_w2_idx", 32'(tbl_index), 7); chk("t1_w2_tgt", 32'(tbl_target), 3); tick();
    mid(); chk("t1_idle_wen", 32'(tbl_wen), 0); chk("t1_idle_busy", 32'(drain_busy), 0); tick();

    // Root lookup through table[5]=2, with an en=0 hold on the way.
    push(5, 9); pulse_row();
    en = 1'b0; mid(); chk("t2_en0_wen", 32'(tbl_wen), 0); tick();
    en = 1'b1; mid(); chk("t2_raddr", 32'(tbl_raddr), 5); chk("t2_idx", 32'(tbl_index), 9);
    chk("t2_tgt", 32'(tbl_target), 2); tick();
    mid(); chk("t2_after_wen", 32'(tbl_wen), 0); tick();

    // New label preempts the pending S2 write.
    push(4, 8); pulse_row();
    new_label_valid = 1'b1; new_label = 8'd12;
    mid(); chk("t3_nl_wen", 32'(tbl_wen), 1); chk("t3_nl_idx", 32'(tbl_index), 12);
    chk("t3_nl_tgt", 32'(tbl_target), 12); tick(); new_label_valid = 1'b0;
    mid(); chk("t3_held_idx", 32'(tbl_index), 8); chk("t3_held_tgt", 32'(tbl_target), 4); tick();
    mid(); chk("t3_after_wen", 32'(tbl_wen), 0); tick();

    // Six distinct pairs into a four-deep bank.
    for (int k = 1; k <= 6; k++) push(k, k + 9);
    mid(); chk("t4_overflow", 32'(overflow), 1); chk("t4_drop", 32'(drop_count), 2); tick();
    base = dr_cnt; pulse_row();
    mid(); chk("t4_first_idx", 32'(tbl_index), 13);
    repeat (7) tick();
    chk("t4_writes", 32'(dr_cnt - base), 4);

    // Duplicate suppression within a row, re-accept after swap.
    push(1, 4); push(1, 4); push(1, 4);
    chk("t5_drop", 32'(drop_count), 2);
    base = dr_cnt;
    row_start = 1'b1; merge_valid = 1'b1; merge_min = 8'd1; merge_max = 8'd4;
    tick(); row_start = 1'b0; merge_valid = 1'b0;
    repeat (5) tick();
    chk("t5_writes_row", 32'(dr_cnt - base), 1);
    base = dr_cnt; pulse_row(); repeat (5) tick();
    chk("t5_writes_reaccept", 32'(dr_cnt - base), 1);
    chk("t5_drop_after", 32'(drop_count), 2);

    // Swap again before the drain bank empties.
    chk("t6_late_before", 32'(late_drain), 0);
    push(10, 20); push(11, 21); push(12, 22);
    row_start = 1'b1; tick();
    mid(); chk("t6_w1_idx", 32'(tbl_index), 22); chk("t6_late_mid", 32'(late_drain), 0);
    tick(); row_start = 1'b0;
    chk("t6_late_set", 32'(late_drain), 1);
    mid(); chk("t6_gap_wen", 32'(tbl_wen), 0); chk("t6_gap_busy", 32'(drain_busy), 0);
    repeat (3) tick();
    base = dr_cnt; pulse_row();
    mid(); chk("t6_w2_idx", 32'(tbl_index), 21); tick();
    mid(); chk("t6_w3_idx", 32'(tbl_index), 20); tick();
    chk("t6_writes", 32'(dr_cnt - base), 2);

    // Asynchronous reset in the middle of a drain.
    push(30, 40); push(31, 41); push(32, 42); pulse_row();
    mid(); chk("t7_pre_wen", 32'(tbl_wen), 1);
    #1 reset_n = 1'b0; #1;
    chk("t7_rst_wen", 32'(tbl_wen), 0); chk("t7_rst_busy", 32'(drain_busy), 0);
    chk("t7_rst_late", 32'(late_drain), 0); chk("t7_rst_ovf", 32'(overflow), 0);
    chk("t7_rst_drop", 32'(drop_count), 0); chk("t7_rst_bank", 32'(push_bank), 0);
    chk("t7_rst_idx", 32'(tbl_index), 0);
    tick(); reset_n = 1'b1;
    base = dr_cnt; pulse_row(); repeat (4) tick(); pulse_row(); repeat (4) tick();
    chk("t7_no_writes", 32'(dr_cnt - base), 0);

    // Randomized rows against a row-level queue model.
    for (int i = 0; i < 256; i++) ref_mt[i] = mt_wr[i] ? env_mt[i] : 8'(i);
    base_dr = act_dr.size(); base_nl = act_nl.size();
    m_drop = 0; m_ovf = 1'b0; m_last_vld = 1'b0; m_last = '0;
    for (int row = 0; row <= 30; row++) begin
      nl_budget = 3;
      for (int c = 0; c < 16; c++) begin
        pv = (row < 30) && (c < 10) && ($urandom_range(1, 0) == 1);
        if (m_last_vld && $urandom_range(3, 0) == 0) p = m_last;
        else begin
          a = $urandom_range(20, 1);
          b = $urandom_range(63, a + 1);
          if ($urandom_range(7, 0) == 0) b = a;
          if ($urandom_range(15, 0) == 0) a = 0;
          p = {8'(b), 8'(a)};
        end
        nlv = (nl_budget > 0) && ($urandom_range(5, 0) == 0);
        if (nlv) nl_budget--;
        lbl = 8'($urandom_range(250, 200));
        row_start = (c == 0); merge_valid = pv; merge_min = p[7:0]; merge_max = p[15:8];
        new_label_valid = nlv; new_label = lbl;
        if (c == 0) begin
          for (int j = cur.size() - 1; j >= 0; j--) exp_dr.push_back(cur[j]);
          cur.delete();
          m_last_vld = 1'b0;
        end
        if (pv && p[7:0] != 0 && p[7:0] != p[15:8]) begin
          if (!(m_last_vld && p == m_last)) begin
            if (cur.size() == 4) begin m_drop++; m_ovf = 1'b1; end
            else begin cur.push_back(p); m_last = p; m_last_vld = 1'b1; end
          end
        end
        if (nlv) exp_nl.push_back(lbl);
        tick();
      end
    end
    row_start = 1'b0; merge_valid = 1'b0; new_label_valid = 1'b0;
    repeat (4) tick();

    chk("rnd_drain_count", 32'(act_dr.size() - base_dr), 32'(exp_dr.size()));
    n = (act_dr.size() - base_dr < exp_dr.size()) ? act_dr.size() - base_dr : exp_dr.size();
    for (int i = 0; i < n; i++) begin
      e = exp_dr[i];
      tgt = ref_mt[e[7:0]];
      chk($sformatf("rnd_dr%0d_idx", i), 32'(act_dr[base_dr + i][15:8]), 32'(e[15:8]));
      chk($sformatf("rnd_dr%0d_tgt", i), 32'(act_dr[base_dr + i][7:0]), 32'(tgt));
      ref_mt[e[15:8]] = tgt;
    end
    chk("rnd_nl_count", 32'(act_nl.size() - base_nl), 32'(exp_nl.size()));
    n = (act_nl.size() - base_nl < exp_nl.size()) ? act_nl.size() - base_nl : exp_nl.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("rnd_nl%0d", i), 32'(act_nl[base_nl + i]), 32'(exp_nl[i]));
    chk("rnd_drop", 32'(drop_count), 32'(m_drop));
    chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    chk("rnd_late", 32'(late_drain), 0);
    chk("rnd_busy", 32'(drain_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
